// File: rtl/phase_shift_dds.sv
`default_nettype none
// ============================================================================
// Module   : phase_shift_dds
// Function : Quarter-wave-ROM sine generator. One shared phase accumulator
//            drives a reference output (offset 0) and NCH phase-shifted
//            outputs. Each channel's offset is staged in a pending register
//            and promoted at accumulator wrap (or on the next cycle), so a
//            channel never shows a phase step mid-period.
// Revision : 1.0  initial release
// ============================================================================
module phase_shift_dds #(
  parameter int                ACC_W    = 32,
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 12,
  parameter int                NCH      = 2,
  parameter bit                SYNC_UPD = 1'b1,
  parameter logic [ACC_W-1:0]  FTW_RST  = 32'h0100_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_flag,
  input  logic [2:0]             set_ch,
  input  logic [ADDR_W-1:0]      point,
  input  logic                   ftw_load,
  input  logic [ACC_W-1:0]       ftw,
  output logic [DATA_W-1:0]      data_out,
  output logic [NCH*DATA_W-1:0]  q,
  output logic                   out_valid,
  output logic [NCH-1:0]         upd_pend
);

  localparam int                c_qw    = ADDR_W - 2;
  localparam int                c_rom_n = 1 << c_qw;
  localparam logic [DATA_W-1:0] c_mid   = {1'b1, {(DATA_W-1){1'b0}}};
  // pi scaled by 2^30 for the fixed-point table generator
  localparam longint            c_pi_s  = 64'sd3373259426;

  // Quarter-wave entry: round((MID-1)*sin(pi*(2i+1)/2^ADDR_W)), evaluated at
  // elaboration with a 2^30 fixed-point Taylor series so the table needs no
  // external image file.
  function automatic logic [DATA_W-2:0] rom_val(input int idx);
    longint x;
    longint term;
    longint sum;
    longint amp;
    x    = (c_pi_s * longint'(2 * idx + 1)) >>> ADDR_W;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = longint'(c_mid) - 64'sd1;
    return (DATA_W-1)'((amp * sum + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [DATA_W-2:0] w_rom [0:c_rom_n-1];

  for (genvar i = 0; i < c_rom_n; i++) begin : g_rom
    assign w_rom[i] = rom_val(i);
  end

  // --------------------------------------------------------------------------
  // Phase accumulator and tuning word
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_ftw;
  logic [ACC_W:0]    w_sum;
  logic              w_wrap;
  logic              w_apply;
  logic [ADDR_W-1:0] w_aref;
  logic [2:0]        r_vld;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_ftw};
  assign w_wrap = w_sum[ACC_W];
  assign w_aref = r_acc[ACC_W-1 -: ADDR_W];
  // A frozen accumulator never wraps, so pending offsets must not wait for one
  assign w_apply = (SYNC_UPD == 1'b0) || w_wrap || (r_ftw == '0);

  // Advance the accumulator; a newly loaded tuning word takes effect next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ftw <= FTW_RST;
    end else begin
      r_acc <= w_sum[ACC_W-1:0];
      if (ftw_load) begin
        r_ftw <= ftw;
      end
    end
  end

  // Pipeline-fill tracker: out_valid rises on the third edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[1:0], 1'b1};
    end
  end

  assign out_valid = r_vld[2];

  // --------------------------------------------------------------------------
  // Output lanes: lanes 0..NCH-1 are shifted channels, lane NCH is the reference
  // --------------------------------------------------------------------------
  for (genvar k = 0; k <= NCH; k++) begin : g_lane
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] r_addr;
    logic [c_qw-1:0]   w_idx;
    logic [DATA_W-2:0] r_mag;
    logic              r_neg;
    logic [DATA_W-1:0] r_out;

    if (k < NCH) begin : g_chan
      logic              w_wr;
      logic [ADDR_W-1:0] r_pend;
      logic [ADDR_W-1:0] r_off;
      logic              r_upd;

      assign w_wr = set_flag && (set_ch == 3'(k));

      // Promote the staged offset when allowed; a write in the same cycle
      // re-arms the pending flag so it waits for the following opportunity
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pend <= '0;
          r_off  <= '0;
          r_upd  <= 1'b0;
        end else begin
          if (w_apply && r_upd) begin
            r_off <= r_pend;
            r_upd <= 1'b0;
          end
          if (w_wr) begin
            r_pend <= point;
            r_upd  <= 1'b1;
          end
        end
      end

      assign w_off                  = r_off;
      assign upd_pend[k]            = r_upd;
      assign q[k*DATA_W +: DATA_W]  = r_out;
    end else begin : g_ref
      assign w_off    = '0;
      assign data_out = r_out;
    end

    // Odd quadrants read the quarter table mirrored
    assign w_idx = r_addr[ADDR_W-2] ? ~r_addr[c_qw-1:0] : r_addr[c_qw-1:0];

    // S1 address, S2 table read, S3 sign fold into offset-binary output
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_addr <= '0;
        r_mag  <= '0;
        r_neg  <= 1'b0;
        r_out  <= c_mid;
      end else begin
        r_addr <= w_aref + w_off;
        r_mag  <= w_rom[w_idx];
        r_neg  <= r_addr[ADDR_W-1];
        r_out  <= r_neg ? (c_mid - {1'b0, r_mag}) : (c_mid + {1'b0, r_mag});
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_shift_dds.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_shift_dds
// Function : Directed self-checking bench for phase_shift_dds at defaults
//            (NCH=2, ADDR_W=8, DATA_W=12, SYNC_UPD=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_phase_shift_dds;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        set_flag = 1'b0;
  logic [2:0]  set_ch   = 3'd0;
  logic [7:0]  point    = 8'd0;
  logic        ftw_load = 1'b0;
  logic [31:0] ftw      = 32'h0100_0000;
  logic [11:0] data_out;
  logic [23:0] q;
  logic        out_valid;
  logic [1:0]  upd_pend;

  int n_vec = 0;
  int n_err = 0;
  int n     = 0;
  int hist_ref [0:2047];
  int hist_q0  [0:2047];
  int off_a [2];
  int off_b [2];
  int off_c [2];
  int sw_b  [2];
  int sw_c  [2];

  phase_shift_dds dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_flag  (set_flag),
    .set_ch    (set_ch),
    .point     (point),
    .ftw_load  (ftw_load),
    .ftw       (ftw),
    .data_out  (data_out),
    .q         (q),
    .out_valid (out_valid),
    .upd_pend  (upd_pend)
  );

  always #5 clk = ~clk;

  // Quarter-table entry straight from the sine definition
  function automatic int rom_m(input int i);
    real v;
    v = 2047.0 * $sin(2.0 * 3.14159265358979 * (real'(i) + 0.5) / 256.0);
    return $rtoi(v + 0.5);
  endfunction

  // Expected offset-binary sample at phase address a
  function automatic int sample(input int a);
    int aa;
    int i;
    aa = a & 255;
    i  = aa & 63;
    case (aa >> 6)
      0:       return 2048 + rom_m(i);
      1:       return 2048 + rom_m(63 - i);
      2:       return 2048 - rom_m(i);
      default: return 2048 - rom_m(63 - i);
    endcase
  endfunction

  // Offset visible on channel ch at output edge t
  function automatic int exp_off(input int ch, input int t);
    if (t >= sw_c[ch]) return off_c[ch];
    if (t >= sw_b[ch]) return off_b[ch];
    return off_a[ch];
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic clear_sched();
    for (int c = 0; c < 2; c++) begin
      off_a[c] = 0;
      off_b[c] = 0;
      off_c[c] = 0;
      sw_b[c]  = 1 << 30;
      sw_c[c]  = 1 << 30;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
  endtask

  task automatic write_off(input int ch, input int pt);
    set_ch   = 3'(ch);
    point    = 8'(pt);
    set_flag = 1'b1;
    tick();
    set_flag = 1'b0;
  endtask

  // Run at default tuning word, checking every lane against the ramp model
  task automatic run_to(input int n_end, input string tag);
    int bad_r = 0;
    int bad_0 = 0;
    int bad_1 = 0;
    while (n < n_end) begin
      tick();
      hist_ref[n] = int'(data_out);
      hist_q0[n]  = int'(q[11:0]);
      if (n >= 3) begin
        if (int'(data_out)  != sample(n - 3))                 bad_r++;
        if (int'(q[11:0])   != sample(n - 3 + exp_off(0, n))) bad_0++;
        if (int'(q[23:12])  != sample(n - 3 + exp_off(1, n))) bad_1++;
      end
    end
    check({tag, "_ref_bad"}, bad_r, 0);
    check({tag, "_q0_bad"},  bad_0, 0);
    check({tag, "_q1_bad"},  bad_1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int frozen;
    clear_sched();

    // ---- T1 reset state and pipeline fill ----
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_data",  int'(data_out),  2048);
    check("rst_q0",    int'(q[11:0]),   2048);
    check("rst_q1",    int'(q[23:12]),  2048);
    check("rst_valid", int'(out_valid), 0);
    check("rst_pend",  int'(upd_pend),  0);
    rst_n = 1'b1;
    n = 0;
    tick();
    check("valid_e1", int'(out_valid), 0);
    tick();
    check("valid_e2", int'(out_valid), 0);
    tick();
    check("valid_e3", int'(out_valid), 1);
    check("t1_a0", int'(data_out), 2073);
    run_to(67, "t1a");
    check("t1_a64", int'(data_out), 4095);
    run_to(131, "t1b");
    check("t1_a128", int'(data_out), 2023);
    run_to(195, "t1c");
    check("t1_a192", int'(data_out), 1);

    // ---- T2 offset 64 on ch0, applied at first wrap ----
    clear_sched();
    do_reset();
    off_b[0] = 64;
    sw_b[0]  = 259;
    run_to(10, "t2a");
    write_off(0, 64);
    check("t2_pend_set", int'(upd_pend), 1);
    run_to(255, "t2b");
    check("t2_pend_hold", int'(upd_pend), 1);
    run_to(256, "t2c");
    check("t2_pend_clr", int'(upd_pend), 0);
    run_to(258, "t2d");
    check("t2_q0_pre", int'(q[11:0]), 2023);
    run_to(259, "t2e");
    check("t2_q0_post", int'(q[11:0]), 4095);
    run_to(770, "t2f");
    bad = 0;
    for (int t = 259; t <= 770; t++) begin
      if (hist_q0[t] != hist_ref[t - 192]) bad++;
    end
    check("t2_lag192_bad", bad, 0);

    // ---- T3 retarget ch0 to 128 at cycle 1000, switch at wrap 1024 ----
    off_c[0] = 128;
    sw_c[0]  = 1027;
    run_to(1000, "t3a");
    write_off(0, 128);
    check("t3_pend_set", int'(upd_pend), 1);
    run_to(1023, "t3b");
    check("t3_pend_hold", int'(upd_pend), 1);
    run_to(1024, "t3c");
    check("t3_pend_clr", int'(upd_pend), 0);
    run_to(1026, "t3d");
    check("t3_q0_pre", int'(q[11:0]), 4095);
    run_to(1027, "t3e");
    check("t3_q0_post", int'(q[11:0]), 2023);
    run_to(1300, "t3f");

    // ---- T4 double-speed tuning word, then frozen accumulator ----
    clear_sched();
    do_reset();
    ftw      = 32'h0200_0000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    bad = 0;
    while (n < 300) begin
      tick();
      hist_ref[n] = int'(data_out);
      if (n >= 3) begin
        if (int'(data_out) != sample((n == 3) ? 0 : (2 * n - 7))) bad++;
        if (int'(q[11:0])  != int'(data_out)) bad++;
      end
    end
    check("t4_ramp_bad", bad, 0);
    check("t4_n4", hist_ref[4], 2123);
    bad = 0;
    for (int t = 140; t < 300; t++) begin
      if (hist_ref[t] != hist_ref[t - 128]) bad++;
    end
    check("t4_period128_bad", bad, 0);
    ftw      = 32'h0;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    while (n < 305) tick();
    frozen = int'(data_out);
    while (n < 310) tick();
    check("t4_frozen", int'(data_out), frozen);
    check("t4_frozen_val", int'(data_out), sample(89));
    write_off(1, 32);
    check("t4_pend_set", int'(upd_pend), 2);
    tick();
    check("t4_pend_next", int'(upd_pend), 0);
    while (n < 316) tick();
    check("t4_q1_off", int'(q[23:12]), sample(121));
    check("t4_q0_hold", int'(q[11:0]), sample(89));
    ftw      = 32'h0100_0000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;

    // ---- T5 collisions ----
    clear_sched();
    do_reset();
    off_b[1] = 20;
    sw_b[1]  = 259;
    off_b[0] = 7;
    sw_b[0]  = 259;
    off_c[0] = 40;
    sw_c[0]  = 515;
    run_to(5, "t5a");
    write_off(5, 99);
    check("t5_badch", int'(upd_pend), 0);
    run_to(10, "t5b");
    write_off(1, 10);
    write_off(1, 20);
    check("t5_b2b_pend", int'(upd_pend), 2);
    run_to(20, "t5c");
    write_off(0, 7);
    check("t5_both_pend", int'(upd_pend), 3);
    run_to(255, "t5d");
    write_off(0, 40);
    check("t5_wrap_wr", int'(upd_pend), 1);
    run_to(511, "t5e");
    check("t5_wrap2_hold", int'(upd_pend), 1);
    run_to(512, "t5f");
    check("t5_wrap2_clr", int'(upd_pend), 0);
    run_to(600, "t5g");

    // ---- T6 asynchronous reset mid-period ----
    rst_n = 1'b0;
    #2;
    check("t6_data",  int'(data_out),  2048);
    check("t6_q0",    int'(q[11:0]),   2048);
    check("t6_q1",    int'(q[23:12]),  2048);
    check("t6_valid", int'(out_valid), 0);
    check("t6_pend",  int'(upd_pend),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    clear_sched();
    run_to(300, "t6");
    check("t6_valid_end", int'(out_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
